// File: rtl/cd_rx_ring.sv
// Multi-frame CDBUS receive ring: FRAMES slots, one owned by the writer, up to FRAMES-1 completed frames queued for the host.
// Optional build macro CD_RX_RING_OVERWRITE_EN: a commit into a full ring evicts the oldest frame instead of dropping the new one.
module cd_rx_ring #(
    parameter int FRAMES  = 4,
    parameter int SLOT_AW = 8,
    parameter int CNT_W   = $clog2(FRAMES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         wr_byte,
    input  logic [SLOT_AW-1:0] wr_addr,
    input  logic               wr_en,
    input  logic [SLOT_AW-1:0] wr_len,
    input  logic               wr_err,
    input  logic               switch,
    output logic               switch_fail,
    input  logic [SLOT_AW-1:0] rd_addr,
    input  logic               rd_en,
    output logic [7:0]         rd_byte,
    output logic [SLOT_AW-1:0] rd_len,
    output logic               rd_err,
    input  logic               rd_done,
    input  logic               rd_done_all,
    output logic               unread,
    output logic [CNT_W:0]     frame_cnt
);
    localparam int IDX_W = $clog2(FRAMES);
    localparam int DEPTH = FRAMES << SLOT_AW;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAMES - 1);

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_MAX) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    logic [7:0]         mem_r [DEPTH];
    logic [SLOT_AW-1:0] meta_len_r [FRAMES];
    logic               meta_err_r [FRAMES];
    logic [IDX_W-1:0]   wr_idx_r, rd_idx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               switch_fail_r;
    logic [7:0]         rd_byte_r;

    logic [IDX_W-1:0]   wr_idx_s, rd_idx_s, rd_idx_rel_s;
    logic [CNT_W-1:0]   cnt_s, cnt_rel_s;
    logic               fail_s, meta_we_s;

    // Next ring state: rd_done_all beats rd_done, and a release in the same cycle frees room for a commit.
    always_comb begin
        wr_idx_s     = wr_idx_r;
        rd_idx_s     = rd_idx_r;
        cnt_s        = cnt_r;
        rd_idx_rel_s = rd_idx_r;
        cnt_rel_s    = cnt_r;
        fail_s       = 1'b0;
        meta_we_s    = 1'b0;
        if (rd_done_all) begin
            cnt_s    = {CNT_W{1'b0}};
            rd_idx_s = wr_idx_r;
        end else begin
            if (rd_done && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_rel_s    = cnt_r - CNT_W'(1);
                rd_idx_rel_s = idx_inc(rd_idx_r);
            end else begin
                cnt_rel_s    = cnt_r;
                rd_idx_rel_s = rd_idx_r;
            end
            cnt_s    = cnt_rel_s;
            rd_idx_s = rd_idx_rel_s;
            if (switch) begin
                if (cnt_rel_s != CNT_MAX) begin
                    meta_we_s = 1'b1;
                    wr_idx_s  = idx_inc(wr_idx_r);
                    cnt_s     = cnt_rel_s + CNT_W'(1);
                end else begin
`ifdef CD_RX_RING_OVERWRITE_EN
                    // Oldest frame sits in the slot right after the writer; it becomes the new writer slot.
                    meta_we_s = 1'b1;
                    wr_idx_s  = idx_inc(wr_idx_r);
                    rd_idx_s  = idx_inc(rd_idx_rel_s);
                    fail_s    = 1'b1;
`else
                    fail_s    = 1'b1;
`endif
                end
            end else begin
                meta_we_s = 1'b0;
            end
        end
    end

    // Ring pointers, frame count, per-slot metadata and the loss pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_r      <= {IDX_W{1'b0}};
            rd_idx_r      <= {IDX_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            switch_fail_r <= 1'b0;
            for (int i = 0; i < FRAMES; i++) begin
                meta_len_r[i] <= {SLOT_AW{1'b0}};
                meta_err_r[i] <= 1'b0;
            end
        end else begin
            wr_idx_r      <= wr_idx_s;
            rd_idx_r      <= rd_idx_s;
            cnt_r         <= cnt_s;
            switch_fail_r <= fail_s;
            if (meta_we_s) begin
                meta_len_r[wr_idx_r] <= wr_len;
                meta_err_r[wr_idx_r] <= wr_err;
            end else begin
                meta_err_r[wr_idx_r] <= meta_err_r[wr_idx_r];
            end
        end
    end

    // Frame byte storage; a read of the address being written returns the previous byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_byte_r <= 8'h00;
        end else begin
            if (wr_en) begin
                mem_r[{wr_idx_r, wr_addr}] <= wr_byte;
            end else begin
                rd_byte_r <= rd_byte_r;
            end
            if (rd_en) begin
                rd_byte_r <= mem_r[{rd_idx_r, rd_addr}];
            end else begin
                rd_byte_r <= rd_byte_r;
            end
        end
    end

    assign rd_byte     = rd_byte_r;
    assign switch_fail = switch_fail_r;
    assign rd_len      = meta_len_r[rd_idx_r];
    assign rd_err      = meta_err_r[rd_idx_r];
    assign unread      = (cnt_r != {CNT_W{1'b0}});
    assign frame_cnt   = {1'b0, cnt_r};

endmodule

// File: tb/tb_cd_rx_ring.sv
// Bench for cd_rx_ring (FRAMES=4, SLOT_AW=8): queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cd_rx_ring;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_byte;
    logic [7:0] wr_addr;
    logic       wr_en;
    logic [7:0] wr_len;
    logic       wr_err;
    logic       switch;
    logic       switch_fail;
    logic [7:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_byte;
    logic [7:0] rd_len;
    logic       rd_err;
    logic       rd_done;
    logic       rd_done_all;
    logic       unread;
    logic [2:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    cd_rx_ring #(.FRAMES(4), .SLOT_AW(8)) dut (
        .clk(clk), .reset(reset),
        .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_len(wr_len), .wr_err(wr_err), .switch(switch), .switch_fail(switch_fail),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_byte(rd_byte),
        .rd_len(rd_len), .rd_err(rd_err), .rd_done(rd_done), .rd_done_all(rd_done_all),
        .unread(unread), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed frames as a FIFO of (slot, len, err); bytes per slot.
    logic [7:0] mem_m   [4][256];
    bit         known_m [4][256];
    int  q_slot[$];
    int  q_len[$];
    int  q_err[$];
    int  wslot     = 0;
    bit  live      = 0;
    bit  exp_fail  = 0;
    logic [7:0] exp_byte = 8'h00;
    bit  exp_known = 0;

    always @(posedge clk) begin
        int rs;
        if (reset) begin
            q_slot.delete(); q_len.delete(); q_err.delete();
            wslot = 0; exp_fail = 0; exp_byte = 8'h00; exp_known = 1; live = 1;
        end else if (live) begin
            rs = (q_slot.size() > 0) ? q_slot[0] : wslot;
            if (rd_en) begin
                exp_byte  = mem_m[rs][rd_addr];
                exp_known = known_m[rs][rd_addr];
            end
            if (wr_en) begin
                mem_m[wslot][wr_addr]   = wr_byte;
                known_m[wslot][wr_addr] = 1;
            end
            exp_fail = 0;
            if (rd_done_all) begin
                q_slot.delete(); q_len.delete(); q_err.delete();
            end else begin
                if (rd_done && q_slot.size() > 0) begin
                    void'(q_slot.pop_front()); void'(q_len.pop_front()); void'(q_err.pop_front());
                end
                if (switch) begin
                    if (q_slot.size() < 3) begin
                        q_slot.push_back(wslot); q_len.push_back(int'(wr_len)); q_err.push_back(int'(wr_err));
                        wslot = (wslot + 1) % 4;
                    end else begin
                        exp_fail = 1;
`ifdef CD_RX_RING_OVERWRITE_EN
                        void'(q_slot.pop_front()); void'(q_len.pop_front()); void'(q_err.pop_front());
                        q_slot.push_back(wslot); q_len.push_back(int'(wr_len)); q_err.push_back(int'(wr_err));
                        wslot = (wslot + 1) % 4;
`endif
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("model_unread", unread, (q_slot.size() != 0));
            chk("model_frame_cnt", frame_cnt, q_slot.size());
            chk("model_switch_fail", switch_fail, exp_fail);
            if (q_slot.size() != 0) begin
                chk("model_rd_len", rd_len, q_len[0]);
                chk("model_rd_err", rd_err, q_err[0]);
            end
            if (exp_known) chk("model_rd_byte", rd_byte, exp_byte);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int addr, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 8'(addr); wr_byte = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic fill(input int slot, input int n);
        for (int off = 0; off < n; off++) wr(off, 8'(slot * 16 + off));
    endtask

    task automatic commit(input int len, input logic err);
        switch = 1'b1; wr_len = 8'(len); wr_err = err;
        tick();
        switch = 1'b0;
    endtask

    task automatic rdone();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic rd(input int addr);
        rd_en = 1'b1; rd_addr = 8'(addr);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_byte"}, rd_byte, 8'h00);
        chk({tag, "_switch_fail"}, switch_fail, 1'b0);
        chk({tag, "_unread"}, unread, 1'b0);
        chk({tag, "_frame_cnt"}, frame_cnt, 3'd0);
        chk({tag, "_rd_len"}, rd_len, 8'h00);
        chk({tag, "_rd_err"}, rd_err, 1'b0);
    endtask

    initial begin
        reset = 1'b1; wr_byte = 8'h00; wr_addr = 8'h00; wr_en = 1'b0; wr_len = 8'h00; wr_err = 1'b0;
        switch = 1'b0; rd_addr = 8'h00; rd_en = 1'b0; rd_done = 1'b0; rd_done_all = 1'b0;
        tick(); tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Three frames, then drain them one by one.
        fill(0, 5); commit(5, 1'b0);
        fill(1, 6); commit(6, 1'b1);
        fill(2, 7); commit(7, 1'b0);
        chk("three_frame_cnt", frame_cnt, 3'd3);
        chk("three_rd_len", rd_len, 8'd5);
        chk("three_rd_err", rd_err, 1'b0);
        rd(2);
        chk("frame0_byte2", rd_byte, 8'h02);
        rdone();
        chk("after_done_rd_len", rd_len, 8'd6);
        chk("after_done_rd_err", rd_err, 1'b1);
        rdone(); rdone();
        chk("drained_unread", unread, 1'b0);

        // Fill slots 3,0,1 (wrapping), then a fourth commit into the full ring.
        wr(255, 8'hA5); commit(10, 1'b0);
        wr(255, 8'h3C); commit(11, 1'b0);
        commit(12, 1'b1);
        chk("full_frame_cnt", frame_cnt, 3'd3);
        commit(13, 1'b0);
        chk("full_switch_fail", switch_fail, 1'b1);
        chk("full_keep_cnt", frame_cnt, 3'd3);
        tick();
        chk("fail_one_cycle", switch_fail, 1'b0);
        rd(255);
        chk("slot3_byte255", rd_byte, 8'hA5);
        rdone();
        chk("wrap_rd_len", rd_len, 8'd11);
        rd(255);
        chk("slot0_byte255", rd_byte, 8'h3C);

        // Refill to full, then switch together with rd_done.
        commit(13, 1'b0);
        switch = 1'b1; rd_done = 1'b1; wr_len = 8'd14; wr_err = 1'b0;
        tick();
        switch = 1'b0; rd_done = 1'b0;
        chk("sw_done_no_fail", switch_fail, 1'b0);
        chk("sw_done_cnt", frame_cnt, 3'd3);
        chk("sw_done_rd_len", rd_len, 8'd12);
        rdone(); rdone();
        chk("new_frame_last", rd_len, 8'd14);
        chk("one_left", frame_cnt, 3'd1);

        // rd_done_all with a simultaneous switch discards everything.
        commit(20, 1'b0);
        rd_done_all = 1'b1; switch = 1'b1; wr_len = 8'd21;
        tick();
        rd_done_all = 1'b0; switch = 1'b0;
        chk("all_cnt", frame_cnt, 3'd0);
        chk("all_unread", unread, 1'b0);
        chk("all_no_fail", switch_fail, 1'b0);
        // Empty ring: reader points at the writer slot (slot 1); same-address read returns old data.
        rd_en = 1'b1; rd_addr = 8'h00; wr_en = 1'b1; wr_addr = 8'h00; wr_byte = 8'hBB;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        chk("rdw_old_data", rd_byte, 8'h10);
        commit(22, 1'b0);
        chk("after_all_cnt", frame_cnt, 3'd1);
        chk("after_all_len", rd_len, 8'd22);
        rd(0);
        chk("rdw_new_data", rd_byte, 8'hBB);

        // Reset with frames pending and a write in flight.
        commit(23, 1'b1);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 8'h07; wr_byte = 8'hEE;
        tick();
        chk_reset_vals("midreset");
        reset = 1'b0; wr_en = 1'b0;
        tick();
        wr(0, 8'h77);
        commit(3, 1'b0);
        chk("post_reset_len", rd_len, 8'd3);
        rd(0);
        chk("post_reset_slot0", rd_byte, 8'h77);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cd_rx_ring.md
# cd_rx_ring

Parametrised multi-frame receive buffer for CDBUS: successor to the fixed double-buffered RX RAM, sitting between the RX byte assembler (write side) and the CSR block (read side). It holds up to FRAMES-1 completed frames in a ring of equal-size slots, so bursts of back-to-back frames are not lost while the host is slow to read. One slot is always owned by the writer and is being filled.

## Interface
Parameters:
- FRAMES, 4, number of slots (2..16, any integer); readable capacity FRAMES-1
- SLOT_AW, 8, slot address width; slot size 2^SLOT_AW bytes
- CNT_W, $clog2(FRAMES), width of frame count

Ports:
- clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous reset, active-high
- wr_byte  in  8  byte to store in writer slot
- wr_addr  in  SLOT_AW  byte offset within writer slot
- wr_en  in  1  write strobe
- wr_len  in  SLOT_AW  frame length, sampled on switch
- wr_err  in  1  frame error flag, sampled on switch
- switch  in  1  one-cycle pulse: commit writer slot as a completed frame
- switch_fail  out  1  one-cycle pulse: commit could not be made without loss
- rd_addr  in  SLOT_AW  byte offset within oldest unread frame
- rd_en  in  1  read enable (chip-select gated, power saving)
- rd_byte  out  8  registered read data
- rd_len  out  SLOT_AW  length of oldest unread frame
- rd_err  out  1  error flag of oldest unread frame
- rd_done  in  1  one-cycle pulse: release oldest unread frame
- rd_done_all  in  1  one-cycle pulse: release all unread frames
- unread  out  1  at least one frame readable
- frame_cnt  out  CNT_W+1  number of readable frames

## Operation
- Storage: FRAMES x 2^SLOT_AW byte array, physical address {slot index, offset}; per-slot metadata flops {len, err}.
- State: wr_idx, rd_idx (0..FRAMES-1, increment wraps FRAMES-1 -> 0), cnt (0..FRAMES-1).
- Write: wr_en writes wr_byte at {wr_idx, wr_addr}; offsets wrap within the slot, never into a neighbour.
- Commit (switch, not full, cnt<FRAMES-1): meta[wr_idx] <= {wr_len, wr_err}; wr_idx++; cnt++.
- Commit when full: frame discarded, wr_idx unchanged (writer refills same slot), switch_fail pulses next cycle.
- rd_done with cnt>0: rd_idx++, cnt--. rd_done with cnt==0: ignored.
- rd_done_all: cnt <= 0, rd_idx <= wr_idx.
- Priority in one cycle: rd_done_all > rd_done > switch.
  - switch + rd_done while full: release first, commit succeeds, cnt unchanged, no switch_fail.
  - switch + rd_done_all: everything discarded including the committing frame; cnt=0, rd_idx=wr_idx (unchanged), no switch_fail.
  - rd_done + rd_done_all: treated as rd_done_all.
- unread = (cnt != 0); frame_cnt = cnt.
- rd_len/rd_err: combinational mux of meta[rd_idx]; undefined-but-stable (last value) when unread=0.

## Timing
- Reset values: rd_byte=0, switch_fail=0, unread=0, frame_cnt=0, rd_len=0, rd_err=0; wr_idx=rd_idx=0. RAM contents not reset.
- Reset mid-frame: partial writer data abandoned, all committed frames lost.
- Read latency: rd_byte valid 1 cycle after rd_en with rd_addr; rd_byte holds when rd_en=0.
- Read during write to same address: rd_byte returns old data.
- switch -> unread/frame_cnt/meta visible next cycle.
- rd_done -> rd_idx, rd_len, rd_err, unread updated next cycle; first rd_byte of the next frame needs rd_en one cycle after that.
- switch_fail: registered, high exactly one cycle, the cycle after the failing switch.

## Configuration
- CD_RX_RING_OVERWRITE_EN defined: commit when full overwrites the oldest frame instead of discarding the new one: meta stored, wr_idx++, rd_idx++, cnt stays FRAMES-1, switch_fail still pulses (loss indicator). A host mid-read of the oldest frame sees its data replaced; that is accepted.
- Undefined: commit when full discards the new frame as in Operation.

## Test plan
- FRAMES=4: commit 3 frames (len 5, 6, 7; err 0,1,0) -> frame_cnt=3, rd_len=5, rd_err=0; rd_done -> rd_len=6, rd_err=1; two more rd_done -> unread=0.
- Full (cnt=3) + 4th switch, macro off -> switch_fail one cycle, frame_cnt=3, bytes of frames 1..3 intact; macro on -> rd_len becomes frame 2's length, 4th frame readable last.
- Full + switch and rd_done same cycle -> no switch_fail, frame_cnt=3, new frame readable last.
- Write 0xA5 at offset 255 of slot 3, commit, cycle indices 0..3 -> rd_idx wraps to 0; read offset 255 of that frame returns 0xA5, slot 0 unaffected.
- 2 frames pending, rd_done_all with simultaneous switch -> frame_cnt=0, unread=0, no switch_fail; next commit gives frame_cnt=1.
- Assert reset with frames pending and wr_en active -> next cycle all outputs at reset values; subsequent commit lands in slot 0.
